// File: rtl/mem_arbiter_if.sv
// One port of the memory arbiter. A requester drives req/we/addr/wdata and a
// responder returns rdata/ack; only the arbiter's client ports report err.
interface mem_arbiter_if;
    logic        req;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        err;

    // The memory side has no error line; timeouts are detected by the arbiter.
    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack, err);
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (core/debug) round-robin arbiter in front of a single memory port,
// with a per-transaction wait timeout that aborts with an err pulse.
module mem_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  c,
    mem_arbiter_if.slave  d,
    mem_arbiter_if.master m,
    output logic          busy,
    output logic          owner
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [4:0] LAST_WAIT = 5'(TIMEOUT - 1);

    state_t     state;
    state_t     state_next;
    logic [4:0] wait_count;
    logic       grant;
    logic       grant_port;
    logic       finish_ack;
    logic       finish_err;
    logic       pulse_active;

    // A request seen during the ack/err cycle belongs to the finished transaction.
    assign pulse_active = c.ack | c.err | d.ack | d.err;
    assign busy         = (state == BUSY);
    assign m.req        = busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        grant_port = owner;
        finish_ack = 1'b0;
        finish_err = 1'b0;
        case (state)
            IDLE: begin
                if (!pulse_active && (c.req || d.req)) begin
                    grant      = 1'b1;
                    grant_port = (c.req && d.req) ? ~owner : d.req;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (m.ack) begin
                    finish_ack = 1'b1;
                    state_next = IDLE;
                end else if (wait_count == LAST_WAIT) begin
                    finish_err = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Owner starts at debug so the first contested grant goes to the core.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner      <= 1'b1;
            wait_count <= '0;
            m.we       <= '0;
            m.addr     <= '0;
            m.wdata    <= '0;
            c.ack      <= 1'b0;
            c.err      <= 1'b0;
            c.rdata    <= '0;
            d.ack      <= 1'b0;
            d.err      <= 1'b0;
            d.rdata    <= '0;
        end else begin
            c.ack   <= finish_ack & ~owner;
            c.err   <= finish_err & ~owner;
            c.rdata <= (finish_ack && !owner) ? m.rdata : '0;
            d.ack   <= finish_ack & owner;
            d.err   <= finish_err & owner;
            d.rdata <= (finish_ack && owner) ? m.rdata : '0;
            if (grant) begin
                owner      <= grant_port;
                wait_count <= '0;
                m.we       <= grant_port ? d.we    : c.we;
                m.addr     <= grant_port ? d.addr  : c.addr;
                m.wdata    <= grant_port ? d.wdata : c.wdata;
            end else if (busy && !m.ack) begin
                wait_count <= wait_count + 5'd1;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written
// reset sequence, and randomized transactions against a transaction-level model.
module tb_mem_arbiter;
    localparam int TIMEOUT = 16;
    localparam int NEVER   = 99;

    typedef struct {
        logic        doReset;
        logic        cOn;
        logic        dOn;
        logic [3:0]  cWe;
        logic [31:0] cAddr;
        logic [31:0] cWdata;
        logic [3:0]  dWe;
        logic [31:0] dAddr;
        logic [31:0] dWdata;
        int          latency;
        logic [31:0] rdata;
        logic        holdReq;
        logic        expOwner;
        logic        expAck;
        int          expBusy;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy;
    logic owner;

    mem_arbiter_if cBus ();
    mem_arbiter_if dBus ();
    mem_arbiter_if mBus ();

    mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .c     (cBus),
        .d     (dBus),
        .m     (mBus),
        .busy  (busy),
        .owner (owner)
    );

    always #5 clk = ~clk;

    int          checkCount  = 0;
    int          passCount   = 0;
    int          protoErrors = 0;
    int          memLatency  = NEVER;
    int          memWait     = 0;
    logic [31:0] memData     = '0;
    bit          forceAck    = 1'b0;
    bit          noiseEn     = 1'b0;
    vec_t        table_q[$];

    // Memory responder: acks after memLatency waiting cycles of m_req.
    initial begin
        mBus.ack   = 1'b0;
        mBus.rdata = '0;
        mBus.err   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (forceAck) begin
                mBus.ack   = 1'b1;
                mBus.rdata = $urandom;
            end else if (mBus.req) begin
                mBus.ack   = (memWait == memLatency);
                mBus.rdata = (memWait == memLatency) ? memData : $urandom;
            end else begin
                mBus.ack   = noiseEn ? 1'($urandom_range(0, 1)) : 1'b0;
                mBus.rdata = $urandom;
            end
            @(negedge clk);
            memWait = mBus.req ? memWait + 1 : 0;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if ((cBus.ack && cBus.err) || (dBus.ack && dBus.err) ||
                ((cBus.ack || cBus.err) && (dBus.ack || dBus.err)))
                protoErrors = protoErrors + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount = checkCount + 1;
        if (actual === expected) begin
            passCount = passCount + 1;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyReset();
        reset     = 1'b1;
        cBus.req  = 1'b0;
        dBus.req  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset m_bus", {31'(mBus.req), mBus.we} | mBus.addr | mBus.wdata, 32'h0);
        checkOutput("reset port outs", {30'h0, cBus.ack | cBus.err | dBus.ack | dBus.err, busy}
                    | cBus.rdata | dBus.rdata, 32'h0);
        checkOutput("reset owner", 32'(owner), 32'h1);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        int          firstReq   = -1;
        int          lastReq    = -1;
        int          pulseCyc   = -1;
        int          busyCycles = 0;
        int          ackCnt     = 0;
        int          errCnt     = 0;
        int          loserHits  = 0;
        int          fieldBad   = 0;
        logic [31:0] gotRdata   = '0;
        logic        gotOwner   = 1'b0;
        logic        winAck, winErr, loseOut;
        logic [31:0] winRdata, loseRdata;
        logic [3:0]  eWe;
        logic [31:0] eAddr, eWdata;

        if (v.doReset) applyReset();
        eWe        = v.expOwner ? v.dWe    : v.cWe;
        eAddr      = v.expOwner ? v.dAddr  : v.cAddr;
        eWdata     = v.expOwner ? v.dWdata : v.cWdata;
        memLatency = v.latency;
        memData    = v.rdata;
        cBus.we    = v.cWe;
        cBus.addr  = v.cAddr;
        cBus.wdata = v.cWdata;
        dBus.we    = v.dWe;
        dBus.addr  = v.dAddr;
        dBus.wdata = v.dWdata;
        cBus.req   = v.cOn;
        dBus.req   = v.dOn;
        for (int cyc = 1; cyc <= TIMEOUT + 6; cyc++) begin
            @(posedge clk);
            #1;
            if (firstReq > 0 && !v.holdReq) begin
                if (v.expOwner) dBus.req = 1'b0;
                else            cBus.req = 1'b0;
            end
            if (pulseCyc > 0) begin
                cBus.req = 1'b0;
                dBus.req = 1'b0;
            end
            @(negedge clk);
            if (busy !== mBus.req) fieldBad++;
            if (mBus.req) begin
                busyCycles++;
                if (firstReq < 0) begin
                    firstReq = cyc;
                    gotOwner = owner;
                end
                lastReq = cyc;
                if (mBus.we !== eWe || mBus.addr !== eAddr || mBus.wdata !== eWdata) fieldBad++;
            end
            winAck    = v.expOwner ? dBus.ack   : cBus.ack;
            winErr    = v.expOwner ? dBus.err   : cBus.err;
            winRdata  = v.expOwner ? dBus.rdata : cBus.rdata;
            loseOut   = v.expOwner ? (cBus.ack | cBus.err) : (dBus.ack | dBus.err);
            loseRdata = v.expOwner ? cBus.rdata : dBus.rdata;
            if (winAck) begin
                ackCnt++;
                gotRdata = winRdata;
                pulseCyc = cyc;
            end
            if (winErr) begin
                errCnt++;
                pulseCyc = cyc;
            end
            if (loseOut || loseRdata !== 32'h0) loserHits++;
        end
        cBus.req = 1'b0;
        dBus.req = 1'b0;

        checkOutput({tag, " grant delay"}, 32'(firstReq), 32'd1);
        checkOutput({tag, " owner"}, 32'(gotOwner), 32'(v.expOwner));
        checkOutput({tag, " busy cycles"}, 32'(busyCycles), 32'(v.expBusy));
        checkOutput({tag, " bus fields"}, 32'(fieldBad), 32'd0);
        checkOutput({tag, " ack count"}, 32'(ackCnt), 32'(v.expAck));
        checkOutput({tag, " err count"}, 32'(errCnt), 32'(!v.expAck));
        checkOutput({tag, " pulse timing"}, 32'(pulseCyc), 32'(lastReq + 1));
        checkOutput({tag, " other port"}, 32'(loserHits), 32'd0);
        if (v.expAck) checkOutput({tag, " rdata"}, gotRdata, v.rdata);
    endtask

    function automatic vec_t makeVec(
        input logic doReset, input logic cOn, input logic dOn,
        input logic [3:0] cWe, input logic [31:0] cAddr, input logic [31:0] cWdata,
        input logic [3:0] dWe, input logic [31:0] dAddr, input logic [31:0] dWdata,
        input int latency, input logic [31:0] rdata, input logic holdReq,
        input logic expOwner, input logic expAck, input int expBusy);
        vec_t v;
        v.doReset = doReset;  v.cOn = cOn;        v.dOn = dOn;
        v.cWe = cWe;          v.cAddr = cAddr;    v.cWdata = cWdata;
        v.dWe = dWe;          v.dAddr = dAddr;    v.dWdata = dWdata;
        v.latency = latency;  v.rdata = rdata;    v.holdReq = holdReq;
        v.expOwner = expOwner; v.expAck = expAck; v.expBusy = expBusy;
        return v;
    endfunction

    initial begin
        int   hits;
        logic refOwner;
        cBus.req = 1'b0; cBus.we = '0; cBus.addr = '0; cBus.wdata = '0;
        dBus.req = 1'b0; dBus.we = '0; dBus.addr = '0; dBus.wdata = '0;

        // Expected columns: owner, ack (else err), number of m_req cycles.
        table_q.push_back(makeVec(1, 1, 0, 4'h0, 32'h100, 32'h0, 4'h0, 32'h0, 32'h0,
                                  0, 32'hDEADBEEF, 1, 0, 1, 1));
        table_q.push_back(makeVec(0, 0, 1, 4'h0, 32'h0, 32'h0, 4'b0011, 32'h20, 32'h0000ABCD,
                                  3, 32'h12345678, 1, 1, 1, 4));
        table_q.push_back(makeVec(0, 1, 0, 4'hF, 32'h400, 32'hCAFEF00D, 4'h0, 32'h0, 32'h0,
                                  NEVER, 32'h0, 1, 0, 0, 16));
        table_q.push_back(makeVec(0, 0, 1, 4'h0, 32'h0, 32'h0, 4'h0, 32'h44, 32'h0,
                                  15, 32'h0BADF00D, 1, 1, 1, 16));
        table_q.push_back(makeVec(0, 1, 0, 4'h0, 32'h80, 32'h0, 4'h0, 32'h0, 32'h0,
                                  2, 32'h55AA55AA, 0, 0, 1, 3));
        table_q.push_back(makeVec(1, 1, 1, 4'h1, 32'h1000, 32'h11111111, 4'h2, 32'h2000, 32'h22222222,
                                  1, 32'hA1, 1, 0, 1, 2));
        table_q.push_back(makeVec(0, 1, 1, 4'h1, 32'h1000, 32'h11111111, 4'h2, 32'h2000, 32'h22222222,
                                  1, 32'hA2, 1, 1, 1, 2));
        table_q.push_back(makeVec(0, 1, 1, 4'h1, 32'h1000, 32'h11111111, 4'h2, 32'h2000, 32'h22222222,
                                  1, 32'hA3, 1, 0, 1, 2));
        table_q.push_back(makeVec(0, 1, 1, 4'h1, 32'h1000, 32'h11111111, 4'h2, 32'h2000, 32'h22222222,
                                  1, 32'hA4, 1, 1, 1, 2));
        table_q.push_back(makeVec(0, 0, 1, 4'h0, 32'h0, 32'h0, 4'h8, 32'h3000, 32'h33,
                                  16, 32'h0, 1, 1, 0, 16));
        table_q.push_back(makeVec(0, 1, 1, 4'h4, 32'h5000, 32'h55, 4'h7, 32'h6000, 32'h66,
                                  0, 32'hB0, 0, 0, 1, 1));

        for (int i = 0; i < table_q.size(); i++)
            applyStimulus(table_q[i], $sformatf("vec%0d", i));

        // Reset during the second BUSY cycle discards the transaction.
        applyReset();
        memLatency = NEVER;
        cBus.addr  = 32'h900;
        cBus.req   = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset    = 1'b1;
        cBus.req = 1'b0;
        @(negedge clk);
        checkOutput("midreset busy before", 32'(mBus.req), 32'h1);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        forceAck = 1'b1;
        @(negedge clk);
        checkOutput("midreset m_req", 32'(mBus.req), 32'h0);
        checkOutput("midreset owner", 32'(owner), 32'h1);
        hits = 0;
        for (int i = 0; i < 5; i++) begin
            if (mBus.req || cBus.ack || cBus.err || dBus.ack || dBus.err) hits++;
            @(negedge clk);
        end
        forceAck = 1'b0;
        checkOutput("midreset late ack ignored", 32'(hits), 32'h0);

        // Randomized traffic; the model only tracks who owned the last grant.
        applyReset();
        refOwner = 1'b1;
        noiseEn  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            vec_t       v;
            logic [1:0] pick;
            pick      = 2'($urandom_range(1, 3));
            v.doReset = 1'b0;
            v.cOn     = pick[0];
            v.dOn     = pick[1];
            v.cWe     = 4'($urandom);
            v.cAddr   = $urandom;
            v.cWdata  = $urandom;
            v.dWe     = 4'($urandom);
            v.dAddr   = $urandom;
            v.dWdata  = $urandom;
            v.latency = ($urandom_range(0, 4) == 0) ? int'($urandom_range(TIMEOUT - 1, TIMEOUT + 3))
                                                    : int'($urandom_range(0, 6));
            v.rdata   = $urandom;
            v.holdReq = 1'($urandom_range(0, 1));
            v.expOwner = (v.cOn && v.dOn) ? !refOwner : v.dOn;
            v.expAck   = (v.latency < TIMEOUT);
            v.expBusy  = v.expAck ? v.latency + 1 : TIMEOUT;
            refOwner   = v.expOwner;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            applyStimulus(v, $sformatf("rnd%0d", i));
        end
        noiseEn = 1'b0;

        checkOutput("ack/err exclusivity", 32'(protoErrors), 32'h0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
